sensor_conditioner: RTL

//   Upstream front-end for the smart-home state controller. Synchronises and debounces the four
//   raw switch sensors (front door, rear door, window, fire alarm). Filters the 7-bit temperature
//   bus so that only values held stable for a set time reach the controller. Outputs drive the

---
 rtl/sensor_conditioner.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sensor_conditioner.sv
// Sensor front-end for the smart-home state controller.
// Four debounced switch channels and a stability filter on the 7-bit temperature bus.
// All outputs are registered. sens_change pulses for one cycle after any output changes.

// One switch channel: a 2-flop synchroniser followed by a run-length debouncer.
// The output only follows the synchronised input once the two have differed
// for DB_CYCLES consecutive edges. Any cycle of agreement restarts the count.
module sensor_switch_db #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic db_out,
   output logic flip
);

   localparam int             CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // Output flips at this edge; the top level uses it to build sens_change.
   assign flip = (s2 != db_out) && (cnt == CNT_LAST);

   // Two-stage synchroniser for the asynchronous, possibly bouncing, raw input.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Disagreement run counter. It is cleared whenever the output flips, so it
   // never passes DB_CYCLES-1 and cannot wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         db_out <= 1'b0;
      end else if (s2 == db_out) begin
         cnt <= '0;
      end else if (flip) begin
         db_out <= s2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// Temperature bus filter. The bus crosses the clock domain as a whole word,
// so individual bits are not trusted. A value is only accepted after the
// two-stage register has shown the same word for ST_STABLE consecutive edges.
module sensor_temp_filter #(
   parameter int         ST_STABLE = 8,
   parameter logic [6:0] ST_RESET  = 7'd60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] raw,
   output logic [6:0] st,
   output logic       st_valid,
   output logic       st_change
);

   localparam int            SW_     = $clog2(ST_STABLE + 1);
   localparam logic [SW_-1:0] S_LAST = SW_'(ST_STABLE - 1);

   logic [6:0]     t1;
   logic [6:0]     t2;
   logic [SW_-1:0] scnt;
   logic           stable;
   logic           load;

   assign stable    = (t2 == t1);
   assign load      = stable && (scnt == S_LAST);
   // Rewriting ST with the value it already holds is not a change.
   assign st_change = load && (t2 != st);

   // Two-stage bus register.
   always_ff @(posedge clk) begin
      if (rst) begin
         t1 <= '0;
         t2 <= '0;
      end else begin
         t1 <= raw;
         t2 <= t1;
      end
   end

   // Stability counter. It saturates at S_LAST, so while the bus stays
   // constant ST is reloaded every cycle with the same value.
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt <= '0;
      end else if (!stable) begin
         scnt <= '0;
      end else if (scnt != S_LAST) begin
         scnt <= scnt + SW_'(1);
      end
   end

   // Filtered output register. It holds the neutral value until the first accepted sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ST_RESET;
         st_valid <= 1'b0;
      end else if (load) begin
         st       <= t2;
         st_valid <= 1'b1;
      end
   end

endmodule

// Top level: four switch channels and one temperature channel, with no
// interaction between them, plus the shared change pulse.
module sensor_conditioner #(
   parameter int         DB_CYCLES = 16,
   parameter int         ST_STABLE = 8,
   parameter logic [6:0] ST_RESET  = 7'd60
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic       SFD_raw,
   input  logic       SRD_raw,
   input  logic       SW_raw,
   input  logic       SFA_raw,
   input  logic [6:0] ST_raw,
   output logic       SFD,
   output logic       SRD,
   output logic       SW,
   output logic       SFA,
   output logic [6:0] ST,
   output logic       ST_valid,
   output logic       sens_change
);

   logic [3:0] sw_raw;
   logic [3:0] sw_out;
   logic [3:0] sw_flip;
   logic       st_change;

   assign sw_raw = {SFA_raw, SW_raw, SRD_raw, SFD_raw};

   for (genvar i = 0; i < 4; i++) begin : g_sw
      sensor_switch_db #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk    (clk),
         .rst    (Rst),
         .raw    (sw_raw[i]),
         .db_out (sw_out[i]),
         .flip   (sw_flip[i])
      );
   end

   assign SFD = sw_out[0];
   assign SRD = sw_out[1];
   assign SW  = sw_out[2];
   assign SFA = sw_out[3];

   sensor_temp_filter #(
      .ST_STABLE (ST_STABLE),
      .ST_RESET  (ST_RESET)
   ) u_temp (
      .clk       (clk),
      .rst       (Rst),
      .raw       (ST_raw),
      .st        (ST),
      .st_valid  (ST_valid),
      .st_change (st_change)
   );

   // One pulse for any number of simultaneous output changes. Reset itself never pulses.
   always_ff @(posedge clk) begin
      if (Rst) begin
         sens_change <= 1'b0;
      end else begin
         sens_change <= (|sw_flip) || st_change;
      end
   end

endmodule
